// File: rtl/aurora_tx_ingress_if.sv
// Purpose: AXI4-Stream user ingress bus into aurora_tx_ingress.
// Signals: tvalid/tlast/tdata driven by the user (master), tready returned by the buffer (slave).
interface aurora_tx_ingress_if #(
    parameter int unsigned AXI_DATA_SIZE = 32
);
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic [AXI_DATA_SIZE-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/aurora_tx_ingress.sv
// Purpose: AXI4-Stream ingress FIFO that replays stored beats toward aurora_top,
//          one beat per data slot, store-and-forward framed with a one-slot gap between frames.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   single_lane        1 = slot lasts SINGLE_LANE_DIV cycles, 0 = one cycle
//   link_ready         channel up; a new frame only starts while high
//   s_axis             user stream (slave side), tready combinational from the fill level
//   axi_valid/last/data registered beat toward aurora_top, held for a whole slot
//   fifo_level         stored beats, 0..DEPTH
module aurora_tx_ingress #(
    parameter int unsigned AXI_DATA_SIZE   = 32,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned SINGLE_LANE_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     single_lane,
    input  logic                     link_ready,
    aurora_tx_ingress_if.slave       s_axis,
    output logic                     axi_valid,
    output logic                     axi_last,
    output logic [AXI_DATA_SIZE-1:0] axi_data,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (SINGLE_LANE_DIV > 1) ? $clog2(SINGLE_LANE_DIV) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_e;

    typedef struct packed {
        logic                     last;
        logic [AXI_DATA_SIZE-1:0] data;
    } beat_t;

    beat_t                    mem_q [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]         level_q, level_d;
    logic [LVL_W-1:0]         frames_q, frames_d;
    logic                     ready_en_q;
    logic                     full_c, push_c, pop_c, start_c;
    beat_t                    head_c;

    logic [CNT_W-1:0]         cnt_q, cnt_d, div_m1_c;
    logic                     sl_q, sl_change_c, strobe_c;

    state_e                   state_q, state_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic [AXI_DATA_SIZE-1:0] data_q, data_d;

    // Ingress handshake; tready stays low during reset and for the first cycle after it.
    assign full_c        = (level_q == LVL_W'(DEPTH));
    assign s_axis.tready = ready_en_q & ~full_c;
    assign push_c        = s_axis.tvalid & s_axis.tready;
    assign head_c        = mem_q[rd_ptr_q];

    // Slot timer: a change of single_lane restarts the count and suppresses this cycle's strobe.
    assign div_m1_c    = single_lane ? CNT_W'(SINGLE_LANE_DIV - 1) : '0;
    assign sl_change_c = (single_lane != sl_q);
    assign strobe_c    = ~sl_change_c & (cnt_q == div_m1_c);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sl_change_c || (cnt_q == div_m1_c)) begin
            cnt_d = '0;
        end
    end

    // Start a frame once one is complete, or cut through when full to avoid deadlock.
    assign start_c = link_ready & (level_q != '0) & ((frames_q != '0) | full_c);

    // Output FSM, advanced only on slot strobes.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        pop_c   = 1'b0;
        if (strobe_c) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            unique case (state_q)
                ST_SEND: begin
                    if (last_q) begin
                        state_d = ST_GAP;
                    end else if (level_q != '0) begin
                        pop_c = 1'b1;
                    end
                end
                ST_IDLE, ST_GAP: begin
                    if (start_c) begin
                        state_d = ST_SEND;
                        pop_c   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (pop_c) begin
                valid_d = 1'b1;
                last_d  = head_c.last;
                data_d  = head_c.data;
            end
        end
    end

    // Occupancy and complete-frame bookkeeping.
    always_comb begin
        level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        frames_d = frames_q + LVL_W'(push_c & s_axis.tlast) - LVL_W'(pop_c & head_c.last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            frames_q   <= '0;
            ready_en_q <= 1'b0;
            cnt_q      <= '0;
            sl_q       <= 1'b0;
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q    <= level_d;
            frames_q   <= frames_d;
            ready_en_q <= 1'b1;
            cnt_q      <= cnt_d;
            sl_q       <= single_lane;
            state_q    <= state_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    // Storage array carries no reset; the level gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{last: s_axis.tlast, data: s_axis.tdata};
        end
    end

    assign axi_valid  = valid_q;
    assign axi_last   = last_q;
    assign axi_data   = data_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_aurora_tx_ingress.sv
module tb_aurora_tx_ingress;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SLD   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          single_lane;
    logic          link_ready;
    logic          axi_valid;
    logic          axi_last;
    logic [W-1:0]  axi_data;
    logic [4:0]    fifo_level;

    aurora_tx_ingress_if #(.AXI_DATA_SIZE(W)) s_if ();

    aurora_tx_ingress #(.AXI_DATA_SIZE(W), .DEPTH(DEPTH), .SINGLE_LANE_DIV(SLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .single_lane(single_lane),
        .link_ready (link_ready),
        .s_axis     (s_if),
        .axi_valid  (axi_valid),
        .axi_last   (axi_last),
        .axi_data   (axi_data),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } tb_beat_t;

    typedef struct {
        logic         lr;
        logic         tv;
        logic         tl;
        logic [W-1:0] td;
        logic         ev;
        logic         el;
        logic [W-1:0] ed;
        logic [4:0]   elev;
    } vec_t;

    // Reference model: beats accepted but not yet presented, in order.
    tb_beat_t     sb[$];
    logic [W-1:0] hold_data;
    logic         hold_last;
    logic         rdy_en;
    logic         mon_en;
    logic         after_last;
    int           run_cnt;
    int           zero_cnt;
    int           n_cmp;
    int           n_fail;
    int           cyc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        hold_data  = '0;
        hold_last  = 1'b0;
        rdy_en     = 1'b0;
        after_last = 1'b0;
        run_cnt    = 0;
        zero_cnt   = 0;
    endtask

    // Per-cycle output check: each DIV-cycle run of valid is one beat taken from the model queue.
    task automatic monitor();
        int div;
        tb_beat_t e;
        if (!mon_en) return;
        div = single_lane ? int'(SLD) : 1;
        if (axi_valid) begin
            run_cnt++;
            if ((run_cnt - 1) % div == 0) begin
                if (run_cnt == 1 && after_last) chk("gap_len_ok", 64'(zero_cnt >= div), 64'd1);
                after_last = 1'b0;
                if (sb.size() == 0) begin
                    chk("stale_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 64'(axi_data), 64'(e.data));
                    chk("beat_last", 64'(axi_last), 64'(e.last));
                    hold_data  = e.data;
                    hold_last  = e.last;
                    after_last = e.last;
                end
            end else begin
                chk("beat_hold", 64'({axi_last, axi_data}), 64'({hold_last, hold_data}));
            end
            zero_cnt = 0;
        end else begin
            chk("idle_out", 64'({axi_last, axi_data}), 64'({1'b0, hold_data}));
            run_cnt = 0;
            if (zero_cnt < 1000) zero_cnt++;
        end
        chk("level", 64'(fifo_level), 64'(sb.size()));
        chk("tready", 64'(s_if.tready), 64'(rdy_en && (sb.size() != DEPTH)));
    endtask

    task automatic tick();
        logic         push;
        tb_beat_t     b;
        push = s_if.tvalid & s_if.tready & rst_n;
        b    = '{last: s_if.tlast, data: s_if.tdata};
        @(posedge clk);
        if (push) sb.push_back(b);
        if (rst_n) rdy_en = 1'b1;
        #1;
        cyc++;
        monitor();
    endtask

    task automatic set_lane(input logic v);
        single_lane = v;
        after_last  = 1'b0;
    endtask

    task automatic push_beat(input logic [W-1:0] d, input logic l);
        int guard = 0;
        logic acc;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        do begin
            acc = s_if.tready;
            tick();
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int guard = 0;
        while (!axi_valid && guard < 200) begin
            tick();
            guard++;
        end
        chk(name, 64'(axi_valid), 64'd1);
    endtask

    task automatic drain(input string name);
        int guard = 0;
        link_ready = 1'b1;
        while ((sb.size() != 0 || axi_valid) && guard < 3000) begin
            tick();
            guard++;
        end
        chk(name, 64'(sb.size()), 64'd0);
        repeat (2 * SLD + 2) tick();
    endtask

    task automatic rand_run(input logic lane, input int pv, input int pl, input int n);
        set_lane(lane);
        link_ready = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(15) == 0) link_ready = ~link_ready;
            s_if.tvalid = ($urandom_range(99) < pv);
            s_if.tlast  = ($urandom_range(99) < pl);
            s_if.tdata  = $urandom;
            tick();
        end
        link_ready = 1'b1;
        push_beat($urandom, 1'b1);
        drain("rand_drain");
    endtask

    vec_t vt[18];

    initial begin
        logic [W-1:0] prev;
        int           nb, since, exp_since, guard;
        logic         meas, seen_full, early, saw_nready;
        tb_beat_t     e;

        n_cmp = 0; n_fail = 0; cyc = 0;
        mon_en = 1'b1;
        rst_n = 1'b0;
        single_lane = 1'b0;
        link_ready = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        s_if.tdata = '0;
        model_reset();
        #1;
        chk("rst_tready", 64'(s_if.tready), 64'd0);
        chk("rst_outs", 64'({axi_valid, axi_last, axi_data}), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("tready_after_rst", 64'(s_if.tready), 64'd1);
        repeat (3) tick();

        // 3-beat frame at DIV=1, then two frames held back by link_ready.
        vt[0]  = '{1'b1, 1'b1, 1'b0, 32'hA000_0001, 1'b0, 1'b0, 32'h0,         5'd1};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 32'hA000_0002, 1'b0, 1'b0, 32'h0,         5'd2};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0003, 1'b0, 1'b0, 32'h0,         5'd3};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hA000_0001, 5'd2};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hA000_0002, 5'd1};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hA000_0003, 5'd0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA000_0003, 5'd0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA000_0003, 5'd0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 32'hB000_0001, 1'b0, 1'b0, 32'hA000_0003, 5'd1};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 32'hB000_0002, 1'b0, 1'b0, 32'hA000_0003, 5'd2};
        vt[10] = '{1'b0, 1'b1, 1'b1, 32'hC000_0001, 1'b0, 1'b0, 32'hA000_0003, 5'd3};
        vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA000_0003, 5'd3};
        vt[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hB000_0001, 5'd2};
        vt[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hB000_0002, 5'd1};
        vt[14] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hB000_0002, 5'd1};
        vt[15] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC000_0001, 5'd0};
        vt[16] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hC000_0001, 5'd0};
        vt[17] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hC000_0001, 5'd0};
        for (int i = 0; i < 18; i++) begin
            link_ready  = vt[i].lr;
            s_if.tvalid = vt[i].tv;
            s_if.tlast  = vt[i].tl;
            s_if.tdata  = vt[i].td;
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(axi_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_last", i), 64'(axi_last), 64'(vt[i].el));
            chk($sformatf("vec%0d_data", i), 64'(axi_data), 64'(vt[i].ed));
            chk($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vt[i].elev));
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        repeat (3) tick();

        // DIV=4: each beat held four cycles, then a four-cycle gap.
        set_lane(1'b1);
        repeat (5) tick();
        push_beat(32'hD200_0001, 1'b0);
        push_beat(32'hD200_0002, 1'b1);
        wait_valid("slow_start");
        chk("slow_b1", 64'({axi_last, axi_data}), 64'({1'b0, 32'hD200_0001}));
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("slow_k%0d", k), 64'({axi_valid, axi_last, axi_data}),
                64'({1'b1, (k >= 4), (k >= 4) ? 32'hD200_0002 : 32'hD200_0001}));
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("slow_gap%0d", k), 64'(axi_valid), 64'd0);
        end
        repeat (4) tick();

        // 20-beat frame with tlast only on beat 20: cut-through once full.
        set_lane(1'b0);
        repeat (3) tick();
        seen_full = 1'b0; early = 1'b0; saw_nready = 1'b0;
        nb = 0; guard = 0;
        while (nb < 20 && guard < 300) begin
            logic acc;
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'hE000_0000 + 32'(nb);
            s_if.tlast  = (nb == 19);
            acc = s_if.tready;
            if (!acc) saw_nready = 1'b1;
            tick();
            if (sb.size() == DEPTH) seen_full = 1'b1;
            if (axi_valid && !seen_full) early = 1'b1;
            if (acc) nb++;
            guard++;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        chk("cut_pushed", 64'(nb), 64'd20);
        chk("cut_tready_low", 64'(saw_nready), 64'd1);
        chk("cut_no_early", 64'(early), 64'd0);
        drain("cut_drain");

        // Full FIFO with a pop in the same cycle: tready stays low, no overwrite.
        link_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_beat(32'hF000_0000 + 32'(i), 1'b0);
        chk("full_level", 64'(fifo_level), 64'd16);
        chk("full_tready", 64'(s_if.tready), 64'd0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'hF000_00FF;
        s_if.tlast  = 1'b1;
        link_ready  = 1'b1;
        #1;
        chk("full_pop_tready", 64'(s_if.tready), 64'd0);
        tick();
        chk("full_pop_level", 64'(fifo_level), 64'd15);
        chk("full_pop_beat", 64'({axi_valid, axi_data}), 64'({1'b1, 32'hF000_0000}));
        tick();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        drain("full_drain");

        // Reset mid-frame discards everything; only new data emerges afterwards.
        push_beat(32'h5000_0001, 1'b0);
        push_beat(32'h5000_0002, 1'b0);
        push_beat(32'h5000_0003, 1'b1);
        wait_valid("rst_mid_start");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_outs", 64'({axi_valid, axi_last, axi_data}), 64'd0);
        chk("rst_mid_level", 64'(fifo_level), 64'd0);
        chk("rst_mid_tready", 64'(s_if.tready), 64'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        push_beat(32'h6000_0001, 1'b0);
        push_beat(32'h6000_0002, 1'b1);
        drain("rst_new_drain");

        // single_lane toggled mid-frame: slot counter restarts, beats neither lost nor repeated.
        mon_en = 1'b0;
        link_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_beat(32'h7000_0000 + 32'(i), (i == 5));
        link_ready = 1'b1;
        prev = hold_data;
        nb = 0; since = 0; exp_since = 0; meas = 1'b0; guard = 0;
        while (nb < 6 && guard < 300) begin
            tick();
            guard++;
            since++;
            if (axi_valid && axi_data != prev) begin
                if (meas) begin
                    chk("toggle_restart", 64'(since), 64'(exp_since));
                    meas = 1'b0;
                end
                if (sb.size() == 0) begin
                    chk("toggle_stale", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("toggle_beat", 64'({axi_last, axi_data}), 64'({e.last, e.data}));
                end
                prev = axi_data;
                nb++;
                if (nb == 2) begin single_lane = 1'b1; since = 0; meas = 1'b1; exp_since = SLD + 1; end
                if (nb == 4) begin single_lane = 1'b0; since = 0; meas = 1'b1; exp_since = 2; end
            end
        end
        chk("toggle_count", 64'(nb), 64'd6);
        repeat (6) tick();
        chk("toggle_empty", 64'(sb.size()), 64'd0);
        hold_data  = 32'h7000_0005;
        hold_last  = 1'b0;
        run_cnt    = 0;
        after_last = 1'b0;
        mon_en     = 1'b1;
        tick();

        // Randomised traffic against the queue model.
        rand_run(1'b0, 40, 5, 1500);
        rand_run(1'b1, 60, 20, 1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
